// File: rtl/toeplitz_sched.sv
// Sequencer for the Toeplitz hash datapath: restarts/advances the column lanes
// and XOR-accumulates the columns selected by each raw input bit into one hash per block.
module toeplitz_sched #(
  parameter int BS     = 64,
  parameter int N      = 256,
  parameter int L      = 128,
  parameter int STRIDE = 4,
  localparam int CW    = $clog2(N+1),
  localparam int PW    = $clog2(BS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BS-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                col_restart,
  output logic                col_adv,
  input  logic [STRIDE*L-1:0] cols,
  output logic [L-1:0]        out_hash,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [CW-1:0]       col_idx
);

  typedef enum logic [1:0] {S_RESTART, S_LOAD, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [L-1:0]    acc_q, acc_d;
  logic [L-1:0]    out_hash_q, out_hash_d;
  logic [BS-1:0]   word_q, word_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic            in_ready_q, in_ready_d;
  logic            col_restart_q, col_restart_d;
  logic            col_adv_q, col_adv_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [BS-1:0]   word_sh;
  logic            last_slice;

  assign word_sh    = word_q >> ptr_q;
  assign last_slice = (int'(ptr_q) + STRIDE) == BS;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    out_hash_d    = out_hash_q;
    word_d        = word_q;
    ptr_d         = ptr_q;
    col_idx_d     = col_idx_q;
    in_ready_d    = 1'b0;
    col_restart_d = 1'b0;
    col_adv_d     = 1'b0;
    out_valid_d   = 1'b0;
    case (state_q)
      S_RESTART: begin
        acc_d     = '0;
        col_idx_d = '0;
        // Out of reset the pulse has not been issued yet; issue it before LOAD.
        if (col_restart_q) begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
        end else begin
          col_restart_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          word_d    = in_data;
          ptr_d     = '0;
          state_d   = S_RUN;
          col_adv_d = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_RUN: begin
        for (int k = 0; k < STRIDE; k++)
          if (word_sh[k]) acc_d = acc_d ^ cols[k*L +: L];
        ptr_d     = ptr_q + PW'(STRIDE);
        col_idx_d = col_idx_q + CW'(STRIDE);
        if (last_slice) begin
          if (col_idx_d == CW'(N)) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_hash_d  = acc_d;
          end else begin
            state_d    = S_LOAD;
            in_ready_d = 1'b1;
          end
        end else begin
          col_adv_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d       = S_RESTART;
          col_restart_d = 1'b1;
          acc_d         = '0;
          col_idx_d     = '0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_RESTART;
    endcase
    busy_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_RESTART;
      acc_q         <= '0;
      out_hash_q    <= '0;
      word_q        <= '0;
      ptr_q         <= '0;
      col_idx_q     <= '0;
      in_ready_q    <= 1'b0;
      col_restart_q <= 1'b0;
      col_adv_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      out_hash_q    <= out_hash_d;
      word_q        <= word_d;
      ptr_q         <= ptr_d;
      col_idx_q     <= col_idx_d;
      in_ready_q    <= in_ready_d;
      col_restart_q <= col_restart_d;
      col_adv_q     <= col_adv_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign col_restart = col_restart_q;
  assign col_adv     = col_adv_q;
  assign out_hash    = out_hash_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign col_idx     = col_idx_q;

endmodule

// File: tb/tb_toeplitz_sched.sv
// Bench for toeplitz_sched: mock column lanes (column j = j), scoreboard of expected hashes.
module tb_toeplitz_sched;
  localparam int BS = 64;
  localparam int N  = 256;
  localparam int L  = 128;
  localparam int ST = 4;
  localparam int CW = $clog2(N+1);

  logic              clk;
  logic              reset;
  logic [BS-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic              col_restart;
  logic              col_adv;
  logic [ST*L-1:0]   cols;
  logic [L-1:0]      out_hash;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [CW-1:0]     col_idx;
  logic              rst_s;

  int n_cmp = 0, n_err = 0;
  int ncyc = 0, n_adv = 0, n_rst = 0, last_rst_cyc = -1;
  logic [L-1:0] exp_q[$];
  int base = 0;

  toeplitz_sched #(.BS(BS), .N(N), .L(L), .STRIDE(ST)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .col_restart(col_restart), .col_adv(col_adv), .cols(cols), .out_hash(out_hash),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .col_idx(col_idx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mock lanes for the main DUT
  always @(posedge clk) begin
    if (col_restart) base <= 0;
    else if (col_adv) base <= base + ST;
  end
  for (genvar k = 0; k < ST; k++) begin : g_lane
    assign cols[k*L +: L] = L'(base + k);
  end

  // Free-running instances at STRIDE 1/2/4, fed the 0xCD block with in_valid/out_ready high
  for (genvar g = 0; g < 3; g++) begin : g_str
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic ir, cr, ca, ov, bz;
    logic [L-1:0] oh;
    logic [S*L-1:0] cl;
    logic [CW-1:0] ci;
    logic [BS-1:0] d;
    int wc, sbase, cyc, first_cyc;
    logic [L-1:0] first_hash;
    for (genvar k = 0; k < S; k++) begin : g_l
      assign cl[k*L +: L] = L'(sbase + k);
    end
    assign d = (wc == 0) ? 64'h20 : ((wc == 3) ? 64'h100 : 64'h0);
    always @(posedge clk) begin
      if (!rst_s) begin
        sbase <= 0; wc <= 0; cyc <= 0; first_cyc <= 0; first_hash <= '0;
      end else begin
        cyc <= cyc + 1;
        if (cr) sbase <= 0;
        else if (ca) sbase <= sbase + S;
        if (ir) wc <= (wc + 1) % 4;
        if (ov && first_cyc == 0) begin
          first_cyc  <= cyc;
          first_hash <= oh;
        end
      end
    end
    toeplitz_sched #(.BS(BS), .N(N), .L(L), .STRIDE(S)) u (
      .clk(clk), .reset(rst_s), .in_data(d), .in_valid(1'b1), .in_ready(ir),
      .col_restart(cr), .col_adv(ca), .cols(cl), .out_hash(oh), .out_valid(ov),
      .out_ready(1'b1), .busy(bz), .col_idx(ci));
  end

  function automatic logic [L-1:0] ref_hash(input logic [3:0][BS-1:0] blk);
    logic [L-1:0] h = '0;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < BS; b++)
        if (blk[w][b]) h = h ^ L'(w*BS + b);
    return h;
  endfunction

  task automatic tick();
    @(negedge clk);
    ncyc++;
    if (col_adv) n_adv++;
    if (col_restart) begin n_rst++; last_rst_cyc = ncyc; end
    n_cmp++;
    if (col_adv && col_restart) begin
      n_err++; $display("FAIL adv_restart_excl: both high at cycle %0d", ncyc);
    end
  endtask

  task automatic send_word(input logic [BS-1:0] d, input int gap);
    int n = 0;
    while (!in_ready && n < 300) begin tick(); n++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL in_ready_timeout: got %b want 1", in_ready); end
    for (int i = 0; i < gap; i++) begin
      tick();
      n_cmp++;
      if (col_adv !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL load_stall: col_adv=%b in_ready=%b want 0/1", col_adv, in_ready);
      end
    end
    in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_block(input logic [3:0][BS-1:0] blk, input logic [L-1:0] exp_h,
                          input int gap, input int rlow, input bit fresh);
    int t0 = ncyc, a0 = n_adv, n = 0;
    logic [L-1:0] e;
    bit keep = out_ready;
    exp_q.push_back(exp_h);
    for (int w = 0; w < 4; w++) send_word(blk[w], gap);
    while (!out_valid && n < 300) begin tick(); n++; end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL out_valid_timeout: got %b want 1", out_valid); end
    e = exp_q.pop_front();
    n_cmp++;
    if (out_hash !== e) begin n_err++; $display("FAIL hash: got %h want %h", out_hash, e); end
    n_cmp++;
    if ((n_adv - a0) * ST != N) begin n_err++; $display("FAIL col_count: got %0d want %0d", (n_adv - a0) * ST, N); end
    n_cmp++;
    if (col_idx !== CW'(N) || busy !== 1'b0) begin
      n_err++; $display("FAIL done_state: col_idx=%0d busy=%b want %0d/0", col_idx, busy, N);
    end
    if (fresh) begin
      n_cmp++;
      if (last_rst_cyc != t0 + 1) begin n_err++; $display("FAIL first_restart: got %0d want %0d", last_rst_cyc - t0, 1); end
      if (gap == 0) begin
        n_cmp++;
        if (ncyc - t0 != 2 + 4*(1 + BS/ST)) begin
          n_err++; $display("FAIL latency: got %0d want %0d", ncyc - t0, 2 + 4*(1 + BS/ST));
        end
      end
    end
    for (int i = 0; i < rlow; i++) begin
      out_ready = 1'b0;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_hash !== e || col_adv !== 1'b0) begin
        n_err++; $display("FAIL done_hold: ov=%b hash=%h adv=%b want 1/%h/0", out_valid, out_hash, col_adv, e);
      end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || col_restart !== 1'b1) begin
      n_err++; $display("FAIL handshake: ov=%b restart=%b want 0/1", out_valid, col_restart);
    end
    out_ready = keep;
  endtask

  task automatic test_reset();
    reset = 1'b0; rst_s = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({in_ready, out_valid, col_adv, col_restart, busy} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready, out_valid, col_adv, col_restart, busy});
    end
    n_cmp++;
    if (out_hash !== '0 || col_idx !== '0) begin
      n_err++; $display("FAIL reset_data: hash=%h idx=%0d want 0/0", out_hash, col_idx);
    end
    reset = 1'b1; rst_s = 1'b1;
  endtask

  task automatic test_zero();
    logic [3:0][BS-1:0] b = '0;
    do_block(b, '0, 0, 0, 1'b1);
  endtask

  task automatic test_patterns();
    logic [3:0][BS-1:0] b;
    b = '1;
    do_block(b, '0, 0, 0, 1'b0);
    b = '0; b[0] = 64'hE;
    do_block(b, '0, 0, 0, 1'b0);
    b = '0; b[0] = 64'h20; b[3] = 64'h100;
    do_block(b, L'(128'hCD), 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    logic [3:0][BS-1:0] b = '0;
    b[0] = 64'h20; b[3] = 64'h100;
    do_block(b, L'(128'hCD), 3, 5, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [3:0][BS-1:0] b;
    b = '1;
    for (int w = 0; w < 3; w++) send_word(b[w], 0);
    repeat (9) tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || col_adv !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: ov=%b adv=%b busy=%b want 0/0/0", out_valid, col_adv, busy);
    end
    tick();
    reset = 1'b1;
    b = '0; b[1] = 64'h8000_0000_0000_0001; b[2] = 64'h3;
    do_block(b, ref_hash(b), 0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0][BS-1:0] b;
    int r0 = n_rst;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 4; w++) b[w] = {$urandom, $urandom};
      do_block(b, ref_hash(b), 0, 0, 1'b0);
    end
    n_cmp++;
    if (n_rst - r0 != 3) begin n_err++; $display("FAIL b2b_restarts: got %0d want 3", n_rst - r0); end
    out_ready = 1'b0;
  endtask

  task automatic test_strides();
    int cy[3];
    logic [L-1:0] hs[3];
    int sv[3] = '{1, 2, 4};
    cy[0] = g_str[0].first_cyc; hs[0] = g_str[0].first_hash;
    cy[1] = g_str[1].first_cyc; hs[1] = g_str[1].first_hash;
    cy[2] = g_str[2].first_cyc; hs[2] = g_str[2].first_hash;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (hs[i] !== L'(128'hCD)) begin n_err++; $display("FAIL stride%0d_hash: got %h want cd", sv[i], hs[i]); end
      n_cmp++;
      if (cy[i] != 2 + 4*(1 + BS/sv[i])) begin
        n_err++; $display("FAIL stride%0d_latency: got %0d want %0d", sv[i], cy[i], 2 + 4*(1 + BS/sv[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_patterns();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_strides();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
